// File: rtl/miller_frame_encoder.sv
// miller_frame_encoder: Miller (delay-modulation) line encoder.
// Accepts words over valid/ready, prepends a preamble, serialises MSB-first
// and drives a Miller-coded level at a programmable half-bit rate.
// Optional feature macro: MILLER_PARITY_EN appends an even-parity bit per word.
module miller_frame_encoder #(
  parameter int                       DATA_W        = 8,
  parameter int                       PREAMBLE_BITS = 8,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE      = 8'hAA,
  parameter int                       HALF_DIV      = 1,
  parameter logic                     IDLE_LEVEL    = 1'b0
) (
  input  logic              clk2x,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              dout,
  output logic              dout_en,
  output logic              busy,
  output logic              err_underrun
);

  localparam int MAXB  = (DATA_W > PREAMBLE_BITS) ? DATA_W : PREAMBLE_BITS;
  localparam int CNT_W = $clog2(MAXB + 1);
  localparam int DIV_W = $clog2(HALF_DIV + 1);

`ifdef MILLER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_PAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} state_t;
`endif

  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic                     half_q, half_d;      // 0: first half, 1: second half
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                     prev_q, prev_d;      // last bit fully or half sent
  logic                     dout_q, dout_d;
  logic                     dout_en_q, dout_en_d;
  logic                     err_q, err_d;
  logic [DATA_W-1:0]        sr_q, sr_d;
  logic [PREAMBLE_BITS-1:0] pre_sr_q, pre_sr_d;
  logic                     last_q, last_d;
`ifdef MILLER_PARITY_EN
  logic                     par_q, par_d;
`endif

  logic                     tick;
  logic                     cur_bit;
  logic                     nxt_bit;
  logic                     adv;
  logic                     word_end;
  logic                     ready_raw;
  logic [PREAMBLE_BITS-1:0] pre_shift;
  logic [DATA_W-1:0]        sr_shift;

  // Next-state, Miller level and handshake logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    bit_cnt_d = bit_cnt_q;
    prev_d    = prev_q;
    dout_d    = dout_q;
    dout_en_d = dout_en_q;
    err_d     = 1'b0;
    sr_d      = sr_q;
    pre_sr_d  = pre_sr_q;
    last_d    = last_q;
`ifdef MILLER_PARITY_EN
    par_d     = par_q;
`endif
    ready_raw = 1'b0;
    nxt_bit   = 1'b0;
    adv       = 1'b0;
    word_end  = 1'b0;
    tick      = (div_q == DIV_W'(HALF_DIV - 1));
    pre_shift = pre_sr_q << 1;
    sr_shift  = sr_q << 1;

    case (state_q)
      ST_PRE:  cur_bit = pre_sr_q[PREAMBLE_BITS-1];
      ST_DATA: cur_bit = sr_q[DATA_W-1];
`ifdef MILLER_PARITY_EN
      ST_PAR:  cur_bit = par_q;
`endif
      default: cur_bit = 1'b0;
    endcase

    case (state_q)
      ST_IDLE: begin
        ready_raw = 1'b1;
        if (s_valid) begin
          sr_d      = s_data;
          last_d    = s_last;
`ifdef MILLER_PARITY_EN
          par_d     = ^s_data;
`endif
          pre_sr_d  = PREAMBLE;
          state_d   = ST_PRE;
          bit_cnt_d = '0;
          half_d    = 1'b0;
          dout_en_d = 1'b1;
          dout_d    = dout_q ^ (~PREAMBLE[PREAMBLE_BITS-1] & ~prev_q);
        end
      end
      default: begin
        if (!tick) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!half_q) begin
            // Mid-bit: a one toggles the line
            half_d = 1'b1;
            dout_d = dout_q ^ cur_bit;
            prev_d = cur_bit;
          end else begin
            half_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            adv       = 1'b1;
            case (state_q)
              ST_PRE: begin
                pre_sr_d = pre_shift;
                if (bit_cnt_q == CNT_W'(PREAMBLE_BITS - 1)) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
                  nxt_bit   = sr_q[DATA_W-1];
                end else begin
                  nxt_bit = pre_shift[PREAMBLE_BITS-1];
                end
              end
              ST_DATA: begin
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef MILLER_PARITY_EN
                  state_d = ST_PAR;
                  nxt_bit = par_q;
`else
                  word_end = 1'b1;
`endif
                end else begin
                  sr_d    = sr_shift;
                  nxt_bit = sr_shift[DATA_W-1];
                end
              end
`ifdef MILLER_PARITY_EN
              ST_PAR: word_end = 1'b1;
`endif
              default: ;
            endcase

            if (word_end) begin
              adv       = 1'b0;
              ready_raw = ~last_q;
              if (!last_q && s_valid) begin
                // Back-to-back word: continue without a line gap
                sr_d      = s_data;
                last_d    = s_last;
`ifdef MILLER_PARITY_EN
                par_d     = ^s_data;
`endif
                state_d   = ST_DATA;
                bit_cnt_d = '0;
                adv       = 1'b1;
                nxt_bit   = s_data[DATA_W-1];
              end else begin
                state_d   = ST_IDLE;
                div_d     = '0;
                half_d    = 1'b0;
                bit_cnt_d = '0;
                prev_d    = 1'b1;
                dout_d    = IDLE_LEVEL;
                dout_en_d = 1'b0;
                err_d     = ~last_q;
              end
            end

            // Bit boundary: two consecutive zeros toggle the line
            if (adv) begin
              dout_d = dout_q ^ (~nxt_bit & ~prev_q);
            end
          end
        end
      end
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk2x) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      half_q    <= 1'b0;
      bit_cnt_q <= '0;
      prev_q    <= 1'b1;
      dout_q    <= IDLE_LEVEL;
      dout_en_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      bit_cnt_q <= bit_cnt_d;
      prev_q    <= prev_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      err_q     <= err_d;
    end
  end

  // Word and preamble shift registers; only read once loaded
  always_ff @(posedge clk2x) begin
    sr_q     <= sr_d;
    pre_sr_q <= pre_sr_d;
    last_q   <= last_d;
`ifdef MILLER_PARITY_EN
    par_q    <= par_d;
`endif
  end

  assign s_ready      = ready_raw & ~rst;
  assign dout         = dout_q;
  assign dout_en      = dout_en_q;
  assign busy         = (state_q != ST_IDLE);
  assign err_underrun = err_q;

endmodule

// File: tb/tb_miller_frame_encoder.sv
// Bench for miller_frame_encoder: five instances (HALF_DIV 1/2/5/3 with
// default framing, plus a 1-bit-preamble 2-bit-word instance), compared
// against a bit-list Miller reference model.
module tb_miller_frame_encoder;
  localparam int NI = 5;
`ifdef MILLER_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif

  logic       clk2x = 1'b0;
  logic       rst;
  logic       s_valid_a  [NI];
  logic [7:0] s_data_a   [NI];
  logic       s_last_a   [NI];
  logic       s_ready_a  [NI];
  logic       dout_a     [NI];
  logic       dout_en_a  [NI];
  logic       busy_a     [NI];
  logic       err_a      [NI];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] words_q[$];

  always #5 clk2x = ~clk2x;

  for (genvar g = 0; g < 4; g++) begin : g_std
    miller_frame_encoder #(
      .HALF_DIV((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 3)
    ) u_dut (
      .clk2x(clk2x), .rst(rst), .s_valid(s_valid_a[g]), .s_ready(s_ready_a[g]),
      .s_data(s_data_a[g]), .s_last(s_last_a[g]), .dout(dout_a[g]),
      .dout_en(dout_en_a[g]), .busy(busy_a[g]), .err_underrun(err_a[g])
    );
  end

  miller_frame_encoder #(
    .DATA_W(2), .PREAMBLE_BITS(1), .PREAMBLE(1'b1), .HALF_DIV(1)
  ) u_small (
    .clk2x(clk2x), .rst(rst), .s_valid(s_valid_a[4]), .s_ready(s_ready_a[4]),
    .s_data(s_data_a[4][1:0]), .s_last(s_last_a[4]), .dout(dout_a[4]),
    .dout_en(dout_en_a[4]), .busy(busy_a[4]), .err_underrun(err_a[4])
  );

  function automatic int hd_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : (k == 3) ? 3 : 1;
  endfunction
  function automatic int dw_of(input int k);
    return (k == 4) ? 2 : 8;
  endfunction
  function automatic int pb_of(input int k);
    return (k == 4) ? 1 : 8;
  endfunction
  function automatic logic [7:0] pre_of(input int k);
    return (k == 4) ? 8'h01 : 8'hAA;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Sends words_q[0..n-1] on instance k; the final word carries s_last=end_last
  // (0 means the bench withholds the next word, forcing an underrun).
  // rst_at >= 0 asserts reset at the start of that half-bit.
  task automatic run_frame(input int k, input int n, input bit end_last, input int rst_at);
    bit         bq[$];
    int         wend[$];
    bit         expq[$];
    bit         lvl, prv, b, par, f, rdy_exp, wlast;
    logic [7:0] w, pre;
    int         hd, dw, pb, wi, nh;
    hd = hd_of(k); dw = dw_of(k); pb = pb_of(k); pre = pre_of(k);
    // Reference: list of line bits, then Miller halves from the bit list
    for (int i = 0; i < pb; i++) bq.push_back(pre[pb-1-i]);
    for (int j = 0; j < n; j++) begin
      w = words_q[j]; par = 1'b0;
      for (int i = 0; i < dw; i++) begin
        b = w[dw-1-i]; bq.push_back(b); par ^= b;
      end
      if (PBIT == 1) bq.push_back(par);
      wend.push_back(2 * bq.size() - 1);
    end
    lvl = 1'b0; prv = 1'b1;
    foreach (bq[i]) begin
      f = lvl ^ (!bq[i] && !prv);
      expq.push_back(f);
      lvl = f ^ bq[i];
      expq.push_back(lvl);
      prv = bq[i];
    end
    nh = expq.size();

    @(negedge clk2x);
    chk("ready_idle", s_ready_a[k], 1);
    s_valid_a[k] = 1'b1;
    s_data_a[k]  = words_q[0];
    s_last_a[k]  = (n == 1) ? end_last : 1'b0;
    @(posedge clk2x);
    @(negedge clk2x);
    wi = 0;
    for (int h = 0; h < nh; h++) begin
      for (int c = 0; c < hd; c++) begin
        if (h == rst_at && c == 0) begin
          rst = 1'b1; s_valid_a[k] = 1'b0;
          #1 chk("ready_in_rst", s_ready_a[k], 0);
          @(posedge clk2x);
          @(negedge clk2x);
          chk("rst_dout", dout_a[k], 0);
          chk("rst_dout_en", dout_en_a[k], 0);
          chk("rst_busy", busy_a[k], 0);
          chk("rst_err", err_a[k], 0);
          rst = 1'b0;
          #1 chk("ready_after_rst", s_ready_a[k], 1);
          return;
        end
        chk($sformatf("dout k%0d h%0d c%0d", k, h, c), dout_a[k], expq[h]);
        chk("dout_en_frame", dout_en_a[k], 1);
        chk("busy_frame", busy_a[k], 1);
        chk("err_frame", err_a[k], 0);
        wlast   = (wi == n - 1) && end_last;
        rdy_exp = (c == hd - 1) && (h == wend[wi]) && !wlast;
        chk($sformatf("ready k%0d h%0d c%0d", k, h, c), s_ready_a[k], rdy_exp);
        if (rdy_exp && (wi + 1 < n)) begin
          s_valid_a[k] = 1'b1;
          s_data_a[k]  = words_q[wi+1];
          s_last_a[k]  = (wi + 1 == n - 1) ? end_last : 1'b0;
        end else if (h == nh - 1 && c == hd - 1) begin
          s_valid_a[k] = 1'b0;
        end else begin
          s_valid_a[k] = 1'($urandom_range(0, 1));
          s_data_a[k]  = 8'($urandom);
          s_last_a[k]  = 1'($urandom_range(0, 1));
        end
        if (c == hd - 1 && h == wend[wi] && wi + 1 < n) wi++;
        @(negedge clk2x);
      end
    end
    chk("end_dout", dout_a[k], 0);
    chk("end_dout_en", dout_en_a[k], 0);
    chk("end_busy", busy_a[k], 0);
    chk("end_err", err_a[k], !end_last);
    chk("end_ready", s_ready_a[k], 1);
    @(negedge clk2x);
    chk("err_one_pulse", err_a[k], 0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      s_valid_a[k] = 1'b0; s_data_a[k] = 8'h00; s_last_a[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk2x);
    @(negedge clk2x);
    for (int k = 0; k < NI; k++) begin
      chk("reset_dout", dout_a[k], 0);
      chk("reset_dout_en", dout_en_a[k], 0);
      chk("reset_busy", busy_a[k], 0);
      chk("reset_err", err_a[k], 0);
      chk("reset_ready", s_ready_a[k], 0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) chk("ready_post_reset", s_ready_a[k], 1);

    // Minimal frame: preamble 1, word 2'b00 -> halves 0,1,1,1,0,0
    words_q = '{8'h00};
    run_frame(4, 1, 1'b1, -1);

    // Two back-to-back words at HALF_DIV=3
    words_q = '{8'hF0, 8'h0F};
    run_frame(3, 2, 1'b1, -1);

    // Underrun after first word
    words_q = '{8'h5A, 8'h00};
    run_frame(3, 1, 1'b0, -1);

    // Mid-frame reset at half-bit 5, then a clean frame on the same instance
    words_q = '{8'hC3};
    run_frame(0, 1, 1'b1, 5);
    words_q = '{8'h07};
    run_frame(0, 1, 1'b1, -1);

    // Random streams at HALF_DIV 1, 2, 5 and on the small instance
    for (int k = 0; k < NI; k++) begin
      if (k == 3) continue;
      for (int fr = 0; fr < 4; fr++) begin
        int n;
        n = $urandom_range(1, 3);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back(8'($urandom));
        run_frame(k, n, ($urandom_range(0, 3) != 0), -1);
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
